// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: Moore-style datapath selects per state, with memory
// handshakes on mem_ready_i and a sticky illegal-opcode flag; sync active-high reset.
module multicycle_ctrl (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic [5:0] instr_funct_i,
   input  logic       zero_i,
   input  logic       neg_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       reg_write_o,
   output logic       iord_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] pc_src_o,
   output logic [1:0] mem_to_reg_o,
   output logic [1:0] reg_dst_o,
   output logic [3:0] state_o,
   output logic       illegal_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_R_WB     = 4'd7,
      S_EXEC_I   = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_JR       = 4'd13,
      S_HALT     = 4'd15
   } state_t;

   typedef enum logic [1:0] {BR_EQ, BR_NE, BR_GT, BR_GEZ} br_t;

   state_t state_q, state_d;
   br_t    br_q, br_d;
   logic   illegal_q;
   logic   br_taken;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         br_q      <= BR_EQ;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) br_q <= br_d;
         if (state_d == S_HALT) illegal_q <= 1'b1;
      end
   end

   // Branch flavour is captured in DECODE so BRANCH never looks at the opcode.
   always_comb begin
      br_d = BR_EQ;
      case (instr_op_i)
         6'b000101: br_d = BR_NE;
         6'b000111: br_d = BR_GT;
         6'b000001: br_d = BR_GEZ;
         default:   br_d = BR_EQ;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (br_q)
         BR_EQ:  br_taken = zero_i;
         BR_NE:  br_taken = !zero_i;
         BR_GT:  br_taken = !zero_i && !neg_i;
         BR_GEZ: br_taken = !neg_i;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      iord_o       = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      pc_src_o     = 2'b00;
      mem_to_reg_o = 2'b00;
      reg_dst_o    = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            alu_op_o    = 3'b110;
            // A ready seen while reset is held must not commit the fetch.
            ir_write_o  = mem_ready_i && !rst_i;
            pc_write_o  = mem_ready_i && !rst_i;
            if (mem_ready_i) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b_o = 2'b11;
            alu_op_o    = 3'b110;
            case (instr_op_i)
               6'b000000: state_d = (instr_funct_i == 6'b001000) ? S_JR : S_EXEC_R;
               6'b100011, 6'b101011: state_d = S_MEM_ADDR;
               6'b001000: state_d = S_EXEC_I;
               6'b000100, 6'b000101, 6'b000111, 6'b000001: state_d = S_BRANCH;
               6'b000010: state_d = S_JUMP;
               6'b000011: state_d = S_JAL;
               default:   state_d = S_HALT;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b110;
            state_d     = (instr_op_i == 6'b101011) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            iord_o     = 1'b1;
            mem_read_o = 1'b1;
            if (mem_ready_i) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write_o = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEM_WR: begin
            iord_o      = 1'b1;
            mem_write_o = 1'b1;
            if (mem_ready_i) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b010;
            state_d     = S_R_WB;
         end
         S_R_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 2'b01;
            reg_dst_o    = 2'b01;
            state_d      = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = 3'b110;
            state_d     = S_I_WB;
         end
         S_I_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 2'b01;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = (br_q == BR_GEZ) ? 3'b101 : 3'b001;
            pc_src_o    = 2'b01;
            pc_write_o  = br_taken;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            pc_src_o   = 2'b10;
            pc_write_o = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            pc_src_o     = 2'b10;
            pc_write_o   = 1'b1;
            reg_write_o  = 1'b1;
            mem_to_reg_o = 2'b11;
            reg_dst_o    = 2'b10;
            state_d      = S_FETCH;
         end
         S_JR: begin
            pc_src_o   = 2'b11;
            pc_write_o = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   assign state_o   = state_q;
   assign illegal_o = illegal_q;

endmodule
